tcb_lib_arbiter: RTL and testbench

- Shares one TCB subordinate between MPN TCB managers.
- Forwards the granted manager's request on the manager-side port.
- Tracks each accepted transfer through a DLY-deep response pipeline, then routes the fixed-delay response (rdt/err) back to the manager that issued it.
- Sits between CPU/DMA managers and a shared memory or peripheral port; a register slice such as tcb_lib_register_response may follow it.

---
 rtl/tcb_lib_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_tcb_lib_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcb_lib_arbiter.sv
// TCB arbiter: MPN managers share one subordinate, responses routed after DLY cycles.
// Optional TCB_LIB_ARBITER_LOCK_EN adds sub_lck for locked (atomic) transfer sequences.
module tcb_lib_arbiter #(
  parameter int unsigned MPN = 2,
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned SLW = 8,
  parameter int unsigned BEW = DBW/SLW,
  parameter int unsigned DLY = 1,
  parameter int unsigned PRI = 0
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [MPN-1:0]     sub_vld,
  input  logic [MPN-1:0]     sub_wen,
  input  logic [MPN*ABW-1:0] sub_adr,
  input  logic [MPN*BEW-1:0] sub_ben,
  input  logic [MPN*DBW-1:0] sub_wdt,
`ifdef TCB_LIB_ARBITER_LOCK_EN
  input  logic [MPN-1:0]     sub_lck,
`endif
  output logic [MPN-1:0]     sub_rdy,
  output logic [MPN*DBW-1:0] sub_rdt,
  output logic [MPN-1:0]     sub_err,
  output logic               man_vld,
  output logic               man_wen,
  output logic [ABW-1:0]     man_adr,
  output logic [BEW-1:0]     man_ben,
  output logic [DBW-1:0]     man_wdt,
  input  logic               man_rdy,
  input  logic [DBW-1:0]     man_rdt,
  input  logic               man_err
);

  localparam int unsigned IW = (MPN > 1) ? $clog2(MPN) : 1;
  typedef logic [IW-1:0] idx_t;

  idx_t ptr_q, ptr_d;
  idx_t hld_idx_q, hld_idx_d;
  logic hld_q, hld_d;
  idx_t gidx, n;
  logic gv, act, xfer, upd_ptr, req;
  logic rsp_vld;
  idx_t rsp_idx;

`ifdef TCB_LIB_ARBITER_LOCK_EN
  logic lck_q, lck_d;
  idx_t lck_idx_q, lck_idx_d;
`endif

  always_comb begin
    gv   = 1'b0;
    gidx = '0;
    n    = '0;
    if (hld_q) begin
      gv   = 1'b1;
      gidx = hld_idx_q;
    end
`ifdef TCB_LIB_ARBITER_LOCK_EN
    else if (lck_q) begin
      gv   = 1'b1;
      gidx = lck_idx_q;
    end
`endif
    else if (PRI == 0) begin
      for (int k = 1; k <= int'(MPN); k++) begin
        n = idx_t'((int'(ptr_q) + k) % int'(MPN));
        if (!gv && sub_vld[n]) begin
          gv   = 1'b1;
          gidx = n;
        end
      end
    end else begin
      for (int i = 0; i < int'(MPN); i++) begin
        if (!gv && sub_vld[i]) begin
          gv   = 1'b1;
          gidx = idx_t'(i);
        end
      end
    end
  end

  // a locked manager owns the bus, so only its own valid counts
`ifdef TCB_LIB_ARBITER_LOCK_EN
  assign req = lck_q ? sub_vld[lck_idx_q] : |sub_vld;
`else
  assign req = |sub_vld;
`endif

  assign man_vld = rst & req;
  assign act     = gv & man_vld;
  assign xfer    = man_vld & man_rdy;

  always_comb begin
    man_wen = 1'b0;
    man_adr = '0;
    man_ben = '0;
    man_wdt = '0;
    sub_rdy = '0;
    if (act) begin
      man_wen       = sub_wen[gidx];
      man_adr       = sub_adr[gidx*ABW +: ABW];
      man_ben       = sub_ben[gidx*BEW +: BEW];
      man_wdt       = sub_wdt[gidx*DBW +: DBW];
      sub_rdy[gidx] = man_rdy;
    end
  end

`ifdef TCB_LIB_ARBITER_LOCK_EN
  always_comb begin
    lck_d     = lck_q;
    lck_idx_d = lck_idx_q;
    upd_ptr   = xfer;
    if (xfer) begin
      if (sub_lck[gidx]) begin
        lck_d     = 1'b1;
        lck_idx_d = gidx;
        upd_ptr   = 1'b0;
      end else begin
        lck_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lck_q     <= 1'b0;
      lck_idx_q <= '0;
    end else begin
      lck_q     <= lck_d;
      lck_idx_q <= lck_idx_d;
    end
  end
`else
  assign upd_ptr = xfer;
`endif

  always_comb begin
    ptr_d     = ptr_q;
    hld_d     = hld_q;
    hld_idx_d = hld_idx_q;
    if (man_vld && !man_rdy) begin
      hld_d     = 1'b1;
      hld_idx_d = gidx;
    end else if (xfer) begin
      hld_d = 1'b0;
    end
    if (upd_ptr) ptr_d = gidx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= idx_t'(MPN-1);
      hld_q     <= 1'b0;
      hld_idx_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      hld_q     <= hld_d;
      hld_idx_q <= hld_idx_d;
    end
  end

  generate
    if (DLY == 0) begin : g_nodly
      assign rsp_vld = xfer;
      assign rsp_idx = gidx;
    end else begin : g_dly
      logic [DLY-1:0] pv_q;
      idx_t           pi_q [DLY];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pv_q <= '0;
          for (int k = 0; k < int'(DLY); k++) pi_q[k] <= '0;
        end else begin
          pv_q[0] <= xfer;
          pi_q[0] <= gidx;
          for (int k = 1; k < int'(DLY); k++) begin
            pv_q[k] <= pv_q[k-1];
            pi_q[k] <= pi_q[k-1];
          end
        end
      end
      assign rsp_vld = pv_q[DLY-1];
      assign rsp_idx = pi_q[DLY-1];
    end
  endgenerate

  always_comb begin
    sub_rdt = '0;
    sub_err = '0;
    if (rsp_vld) begin
      sub_rdt[rsp_idx*DBW +: DBW] = man_rdt;
      sub_err[rsp_idx]            = man_err;
    end
  end

  // a stalled, granted manager must keep its request up
  a_hold_vld: assert property (
    @(posedge clk) disable iff (!rst) hld_q |-> sub_vld[hld_idx_q]
  );

endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// Directed bench for tcb_lib_arbiter: DLY=1 and DLY=2 instances on shared stimulus.
// Lock sequence runs only when TCB_LIB_ARBITER_LOCK_EN is defined.
module tb_tcb_lib_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sub_vld, sub_wen, sub_lck;
  logic [63:0] sub_adr, sub_wdt;
  logic [7:0]  sub_ben;
  logic        man_rdy, man_err;
  logic [31:0] man_rdt;

  logic [1:0]  rdy1, err1, rdy2, err2;
  logic [63:0] rdt1, rdt2;
  logic        mvld1, mwen1, mvld2, mwen2;
  logic [31:0] madr1, mwdt1, madr2, mwdt2;
  logic [3:0]  mben1, mben2;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp;
  logic [31:0] mem;

  always #5 clk = ~clk;

  tcb_lib_arbiter #(.MPN(2), .DLY(1), .PRI(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr),
    .sub_ben(sub_ben), .sub_wdt(sub_wdt),
`ifdef TCB_LIB_ARBITER_LOCK_EN
    .sub_lck(sub_lck),
`endif
    .sub_rdy(rdy1), .sub_rdt(rdt1), .sub_err(err1),
    .man_vld(mvld1), .man_wen(mwen1), .man_adr(madr1),
    .man_ben(mben1), .man_wdt(mwdt1),
    .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err)
  );

  tcb_lib_arbiter #(.MPN(2), .DLY(2), .PRI(0)) u_dut2 (
    .clk(clk), .rst(rst),
    .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr),
    .sub_ben(sub_ben), .sub_wdt(sub_wdt),
`ifdef TCB_LIB_ARBITER_LOCK_EN
    .sub_lck(sub_lck),
`endif
    .sub_rdy(rdy2), .sub_rdt(rdt2), .sub_err(err2),
    .man_vld(mvld2), .man_wen(mwen2), .man_adr(madr2),
    .man_ben(mben2), .man_wdt(mwdt2),
    .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    sub_vld = 2'b11;
    sub_wen = 2'b00;
    sub_lck = 2'b00;
    sub_adr = {32'h200, 32'h100};
    sub_wdt = {32'h22222222, 32'h11111111};
    sub_ben = 8'hFF;
    man_rdy = 1'b1;
    man_rdt = 32'hDEADBEEF;
    man_err = 1'b1;
    #2;
    chk("rst_rdy", rdy1, 2'b00);
    chk("rst_mvld", mvld1, 1'b0);
    chk("rst_rdt", rdt1, 64'h0);
    chk("rst_err", err1, 2'b00);
    chk("rst_rdt2", rdt2, 64'h0);
    cyc;
    cyc;
    rst     = 1'b1;
    man_err = 1'b0;
    #2;
    chk("first_gnt", rdy1, 2'b01);
    chk("first_adr", madr1, 32'h100);
    chk("first_mvld", mvld1, 1'b1);
    sub_vld = 2'b00;
    cyc;

    // single manager write then read
    sub_vld = 2'b10;
    sub_wen = 2'b10;
    sub_adr[63:32] = 32'h10;
    sub_wdt[63:32] = 32'h01234567;
    #2;
    chk("wr_rdy", rdy1, 2'b10);
    chk("wr_wen", mwen1, 1'b1);
    chk("wr_adr", madr1, 32'h10);
    chk("wr_wdt", mwdt1, 32'h01234567);
    mem = 32'h01234567;
    cyc;
    sub_wen = 2'b00;
    #2;
    chk("rd_rdy", rdy1, 2'b10);
    chk("rd_wen", mwen1, 1'b0);
    cyc;
    sub_vld = 2'b00;
    man_rdt = mem;
    #2;
    chk("rd_rdt", rdt1, {mem, 32'h0});
    chk("rd_err", err1, 2'b00);
    cyc;
    man_rdt = 32'hCAFEF00D;
    #2;
    chk("rd_rdt_d2", rdt2, {32'hCAFEF00D, 32'h0});
    chk("rd_idle_d1", rdt1, 64'h0);
    cyc;

    // round-robin contention
    sub_adr = {32'h200, 32'h100};
    for (int i = 0; i <= 6; i++) begin
      sub_vld = (i < 6) ? 2'b11 : 2'b00;
      man_rdt = 32'hA0000000 + i;
      #2;
      if (i < 6)
        chk($sformatf("rr_gnt%0d", i), rdy1, 64'd1 << (i % 2));
      if (i > 0) begin
        exp = '0;
        exp[((i-1)%2)*32 +: 32] = man_rdt;
        chk($sformatf("rr_rsp1_%0d", i), rdt1, exp);
      end
      if (i > 1) begin
        exp = '0;
        exp[((i-2)%2)*32 +: 32] = man_rdt;
        chk($sformatf("rr_rsp2_%0d", i), rdt2, exp);
      end
      cyc;
    end

    // stall: mgr0 held while mgr1 joins
    sub_vld = 2'b01;
    #2;
    chk("pre_gnt", rdy1, 2'b01);
    cyc;
    man_rdy = 1'b0;
    #2;
    chk("stall0_rdy", rdy1, 2'b00);
    chk("stall0_adr", madr1, 32'h100);
    cyc;
    for (int i = 1; i < 3; i++) begin
      sub_vld = 2'b11;
      #2;
      chk($sformatf("stall%0d_adr", i), madr1, 32'h100);
      chk($sformatf("stall%0d_rdy", i), rdy1, 2'b00);
      cyc;
    end
    man_rdy = 1'b1;
    #2;
    chk("unstall_rdy", rdy1, 2'b01);
    cyc;
    #2;
    chk("next_gnt", rdy1, 2'b10);
    cyc;
    sub_vld = 2'b00;
    cyc;

    // error routing
    sub_vld = 2'b10;
    sub_adr[63:32] = 32'hFFFFFFF0;
    #2;
    chk("err_gnt", rdy1, 2'b10);
    chk("err_adr", madr1, 32'hFFFFFFF0);
    cyc;
    sub_vld = 2'b00;
    man_err = 1'b1;
    man_rdt = 32'h0;
    #2;
    chk("err_d1", err1, 2'b10);
    chk("err_d2_early", err2, 2'b00);
    cyc;
    #2;
    chk("err_d1_late", err1, 2'b00);
    chk("err_d2", err2, 2'b10);
    cyc;
    man_err = 1'b0;

`ifdef TCB_LIB_ARBITER_LOCK_EN
    sub_vld = 2'b11;
    sub_lck = 2'b01;
    #2;
    chk("lk_g0", rdy1, 2'b01);
    cyc;
    #2;
    chk("lk_g1", rdy1, 2'b01);
    cyc;
    sub_lck = 2'b00;
    #2;
    chk("lk_g2", rdy1, 2'b01);
    cyc;
    #2;
    chk("lk_rel", rdy1, 2'b10);
    sub_vld = 2'b00;
    cyc;
`endif

    // reset with a response in flight
    sub_vld = 2'b10;
    #2;
    cyc;
    sub_vld = 2'b00;
    man_rdt = 32'h5A5A5A5A;
    #2;
    chk("pre_rst_rdt", rdt1, {32'h5A5A5A5A, 32'h0});
    rst = 1'b0;
    #1;
    chk("mid_rst_rdt", rdt1, 64'h0);
    chk("mid_rst_rdy", rdy1, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
